// File: rtl/mul_seq_ctrl.sv
// Sequential radix-4 Booth multiplier: one partial-product generator and one
// 2*WIDTH adder stepped over WIDTH/2 cycles. MUL_EARLY_TERM_EN enables early exit.
module mul_seq_ctrl #(
    parameter  int WIDTH = 32,
    localparam int N     = WIDTH / 2,
    localparam int IW    = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [IW-1:0]    iter
);

    localparam logic [IW-1:0] N_L = IW'(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mr;
    logic [WIDTH:0]     qs;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mx;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [IW-1:0]      iter_nxt;
    logic               skip;

    // Booth digit selection on the sign-extended multiplicand; negation at
    // 2*WIDTH bits keeps -M and -2M of the most-negative value exact.
    always_comb begin
        mx = {{WIDTH{mr[WIDTH-1]}}, mr};
        pp = '0;
        case (qs[2:0])
            3'b001, 3'b010: pp = mx;
            3'b011:         pp = mx << 1;
            3'b100:         pp = -(mx << 1);
            3'b101, 3'b110: pp = -mx;
            default:        pp = '0;
        endcase
        acc_nxt  = acc + (pp << {iter, 1'b0});
        iter_nxt = iter + 1'b1;
`ifdef MUL_EARLY_TERM_EN
        // All-zero or all-one multiplier remainder only yields 000/111 codes.
        skip = (qs == '0) || (qs == '1);
`else
        skip = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            iter   <= '0;
            acc    <= '0;
            mr     <= '0;
            qs     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mr    <= M;
                        qs    <= {Q, 1'b0};
                        acc   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (skip) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        res_hi <= acc[2*WIDTH-1:WIDTH];
                        res_lo <= acc[WIDTH-1:0];
                    end else begin
                        acc  <= acc_nxt;
                        qs   <= $signed(qs) >>> 2;
                        iter <= iter_nxt;
                        if (iter_nxt == N_L) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            res_hi <= acc_nxt[2*WIDTH-1:WIDTH];
                            res_lo <= acc_nxt[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: vector table, scoreboard of expected
// products popped on each done pulse, and hand-built handshake sequences.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [31:0] M = '0;
    logic [31:0] Q = '0;
    logic        busy, done;
    logic [31:0] res_hi, res_lo;
    logic [4:0]  iter;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [63:0] sb[$];
    logic [63:0] held = '0;

    mul_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .M(M), .Q(Q),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .iter(iter)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] prod;
        int          lat_et;   // edges incl. start edge with early exit; 0 = unchecked
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (!clr && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("product", {res_hi, res_lo}, sb.pop_front());
            end
            held = {res_hi, res_lo};
        end else if (!clr && busy) begin
            chk("res_hold_run", {res_hi, res_lo}, held);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                          output int lat, output int bcnt);
        @(negedge clk);
        sb.push_back(exp);
        M = m; Q = q; start = 1'b1;
        lat = 0; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            M = $urandom; Q = $urandom;
            if (busy) bcnt++;
            if (done) break;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int lat, bcnt, n, c1, c2, ign_at;
        logic [31:0] rm, rq;

        vt[0] = '{32'd3,         32'd5,         64'h00000000_0000000F, 0};
        vt[1] = '{32'hFFFFFFFF,  32'h7FFFFFFF,  64'hFFFFFFFF_80000001, 0};
        vt[2] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000, 0};
        vt[3] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001, 0};
        vt[4] = '{32'h80000000,  32'd1,         64'hFFFFFFFF_80000000, 0};
        vt[5] = '{32'h00001234,  32'd1,         64'h00000000_00001234, 3};
        vt[6] = '{32'd5,         32'd0,         64'h00000000_00000000, 2};
        vt[7] = '{32'hFFFFFFFC,  32'd6,         64'hFFFFFFFF_FFFFFFE8, 0};
        vt[8] = '{32'h00010000,  32'h00010000,  64'h00000001_00000000, 0};
        vt[9] = '{32'h7FFFFFFF,  32'h80000000,  64'hC0000000_80000000, 0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, res_hi}, 64'd0);
        chk("rst_lo", {32'd0, res_lo}, 64'd0);
        chk("rst_iter", {59'd0, iter}, 64'd0);
        clr = 1'b0;

        foreach (vt[k]) begin
            run_op(vt[k].m, vt[k].q, vt[k].prod, lat, bcnt);
`ifdef MUL_EARLY_TERM_EN
            if (vt[k].lat_et != 0) chk("latency_et", 64'(lat), 64'(vt[k].lat_et));
`else
            chk("latency", 64'(lat), 64'd17);
            chk("busy_cycles", 64'(bcnt), 64'd16);
            chk("iter_final", {59'd0, iter}, 64'd16);
`endif
        end

        for (int r = 0; r < 6; r++) begin
            rm = $urandom; rq = $urandom;
            run_op(rm, rq, 64'($signed(rm) * $signed(rq)), lat, bcnt);
        end

        // start while busy is ignored
`ifdef MUL_EARLY_TERM_EN
        ign_at = 2;
`else
        ign_at = 5;
`endif
        @(negedge clk);
        sb.push_back(64'd63);
        M = 32'd7; Q = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ign_at - 1) @(negedge clk);
        chk("busy_at_ignore", {63'd0, busy}, 64'd1);
        M = 32'd2; Q = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        repeat (20) @(negedge clk);

        // clr mid-RUN discards the operation
        M = 32'd5; Q = 32'h40000001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("busy_before_clr", {63'd0, busy}, 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        held = '0;
        chk("clr_busy", {63'd0, busy}, 64'd0);
        chk("clr_done", {63'd0, done}, 64'd0);
        chk("clr_res", {res_hi, res_lo}, 64'd0);
        chk("clr_iter", {59'd0, iter}, 64'd0);
        repeat (25) @(negedge clk);

        // back-to-back: start held through DONE
        sb.push_back(64'hFFFFFFFF_FFFFFFE8);
        sb.push_back(64'hFFFFFFFF_FFFFFFE8);
        M = 32'hFFFFFFFC; Q = 32'd6; start = 1'b1;
        wait_done(n);
        c1 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(n);
        c2 = cyc;
`ifdef MUL_EARLY_TERM_EN
        chk("b2b_gap", 64'(c2 - c1), 64'd4);
`else
        chk("b2b_gap", 64'(c2 - c1), 64'd17);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequential radix-4 Booth multiply controller for the CPU's MUL instruction.
- Sequences one shared partial-product stage (same Booth recoding as the combinational multiplier) over 16 iterations.
- Accumulates a 64-bit product and presents it as HI/LO with a start/busy/done handshake to the control unit.
- Trades the 16-generator combinational array for one generator plus one 64-bit adder.

Parameters:
- WIDTH, 32, operand width; must be even. Iterations N = WIDTH/2; product width = 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  request; sampled only when not busy.
- M  in  WIDTH  multiplicand (two's complement); captured on accepted start.
- Q  in  WIDTH  multiplier (two's complement); captured on accepted start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when result valid; doubles as HI/LO write enable.
- res_hi  out  WIDTH  product[2*WIDTH-1:WIDTH].
- res_lo  out  WIDTH  product[WIDTH-1:0].
- iter  out  log2(N)+1  iterations completed (debug/verification).

Behaviour:
- Reset: on clk edge with clr=1 → state IDLE; busy=0, done=0, res_hi=0, res_lo=0, iter=0, accumulator=0. clr overrides all other inputs, including mid-RUN; the partial result is discarded and no done pulse is issued.
- States:
  - IDLE: start=1 → capture Mr=M and Qs={Q,1'b0} (WIDTH+1 bits), acc=0, iter=0 → RUN.
  - RUN: busy=1. Each edge:
    - code = Qs[2:0].
    - pp = Booth(Mr, code), sign-extended to 2*WIDTH:
      - 001/010 → +M.
      - 011 → +2M.
      - 100 → −2M.
      - 101/110 → −M.
      - 000/111 → 0.
    - acc += pp << (2*iter), modulo 2^(2*WIDTH).
    - Qs = Qs >>> 2 (arithmetic); iter += 1.
    - When iter reaches N on this edge → DONE, and res_hi/res_lo load from the final acc value.
  - DONE: done=1, busy=0, for exactly one cycle.
    - start=1 in DONE → accepted as in IDLE, go to RUN (back-to-back ops).
    - otherwise → IDLE.
- Latency: start accepted at edge E0 → RUN covers edges E1..EN → done high in the cycle after EN. For WIDTH=32, done is asserted 17 edges after the start edge.
- Handshake:
  - start while busy is ignored; operands are not re-captured.
  - M/Q may change freely after the capture edge.
  - res_hi/res_lo hold their last result until the next DONE load or clr. They do not change during RUN.
- Arithmetic: the signed product is exact for all inputs, including M = Q = −2^(WIDTH−1). Negation is two's complement at 2*WIDTH bits, so −M of the most-negative value does not overflow.
- iter holds its final value in DONE/IDLE; it clears on accepted start.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: at each RUN edge, before the add, if all of Qs[WIDTH:0] are 0 or all are 1, the remaining codes are all 000/111. The controller then skips the add, leaves iter unchanged and goes to DONE; results load from the current acc.
  - Latency ranges from 1 to N RUN edges.
  - Q=0 → done after E1; Q=1 → done after E2.
- Undefined: always N RUN edges; no skip check synthesised.
- The product value is identical in both builds.

Test Plan:
- M=3, Q=5, start pulse → done once at edge 17; res_hi=0x00000000, res_lo=0x0000000F; busy high for exactly 16 cycles.
- M=0xFFFFFFFF (−1), Q=0x7FFFFFFF → res_hi=0xFFFFFFFF, res_lo=0x80000001.
- M=Q=0x80000000 → res_hi=0x40000000, res_lo=0x00000000.
- Start M=7, Q=9; at RUN cycle 5 drive start with M=2, Q=2 → ignored; result 0x0000003F. Then clr at RUN cycle 8 of a new op → busy=0, no done pulse, res_hi=res_lo=0.
- Back-to-back: start held high through DONE with M=−4, Q=6 → second done 17 cycles after the first; res=0xFFFFFFFF_FFFFFFE8.
- With MUL_EARLY_TERM_EN: M=0x1234, Q=1 → done after 2 RUN edges, res_lo=0x1234. Same stimulus without the macro → done after 16 RUN edges with the same result.
